// File: rtl/pipe_ctrl_unit.sv
// Pipelined opcode decoder: decodes op/aluop into a 17-bit control word and carries it through
// STAGES registered stages, with stall/flush policy and a multdiv wait FSM. Option: PIPE_CTRL_ILLEGAL_EN.
module pipe_ctrl_unit #(
    parameter int STAGES     = 3,
    parameter int MD_TIMEOUT = 64
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic [4:0]              op,
    input  logic [4:0]              aluop,
    input  logic                    stall_ext,
    input  logic                    flush,
    input  logic                    md_ready,
    output logic [16:0]             dec_ctrl,
    output logic                    dec_addi,
    output logic                    dec_sw,
    output logic                    dec_lw,
    output logic [17*STAGES-1:0]    ctrl_out,
    output logic [STAGES-1:0]       valid_out,
    output logic                    stall_out,
    output logic                    md_start,
    output logic                    md_timeout,
    output logic                    illegal_op
);

    localparam int              CNT_W    = $clog2(MD_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MD_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_MD_WAIT = 1'b1
    } md_state_t;

    function automatic logic [16:0] decode_word(input logic [4:0] opc);
        logic [16:0] w;
        case (opc)
            5'b00000: w = 17'h00004;
            5'b00101: w = 17'h00016;
            5'b01000: w = 17'h00017;
            5'b00111: w = 17'h00039;
            5'b00001: w = 17'h00200;
            5'b00010: w = 17'h00048;
            5'b00011: w = 17'h00384;
            5'b00100: w = 17'h00408;
            5'b00110: w = 17'h08008;
            5'b10110: w = 17'h11800;
            5'b10101: w = 17'h06004;
            default:  w = 17'h00000;
        endcase
        return w;
    endfunction

`ifdef PIPE_CTRL_ILLEGAL_EN
    function automatic logic opcode_known(input logic [4:0] opc);
        logic k;
        case (opc)
            5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100, 5'b00101,
            5'b00110, 5'b00111, 5'b01000, 5'b10101, 5'b10110: k = 1'b1;
            default:                                          k = 1'b0;
        endcase
        return k;
    endfunction
`endif

    md_state_t                  state_r;
    logic [CNT_W-1:0]           count_r;
    logic [STAGES-1:0][16:0]    ctrl_r;
    logic [STAGES-1:0]          valid_r;
    logic                       md_start_r;
    logic                       md_timeout_r;

    logic [16:0]                entry_ctrl_s;
    logic                       entry_valid_s;
    logic                       is_md_s;
    logic                       in_wait_s;
    logic                       md_hold_s;
    logic                       timeout_hit_s;
    logic                       enter_md_s;

    // Combinational decode of the instruction sitting at decode
    always_comb begin
        dec_ctrl = decode_word(op);
    end

    assign dec_addi = op[2] & ~op[1] & op[0];
    assign dec_sw   = op[2] & op[1] & op[0];
    assign dec_lw   = op[3];

`ifdef PIPE_CTRL_ILLEGAL_EN
    assign illegal_op = in_valid & (~opcode_known(op) | ((op == 5'b00000) & (aluop > 5'b01001)));
`else
    assign illegal_op = 1'b0;
`endif

    // Word presented to stage 0: illegal instructions are turned into bubbles
    always_comb begin
        if (illegal_op) begin
            entry_ctrl_s  = 17'h00000;
            entry_valid_s = 1'b0;
        end else begin
            entry_ctrl_s  = dec_ctrl;
            entry_valid_s = in_valid;
        end
    end

    assign is_md_s       = (op == 5'b00000) & ((aluop == 5'b00110) | (aluop == 5'b00111));
    assign in_wait_s     = (state_r == ST_MD_WAIT);
    // The last counted cycle releases the pipe itself rather than waiting one more edge
    assign md_hold_s     = in_wait_s & ~md_ready & ~flush & (count_r != CNT_LAST);
    assign timeout_hit_s = in_wait_s & ~md_ready & ~flush & (count_r == CNT_LAST);
    assign stall_out     = stall_ext | md_hold_s;
    assign enter_md_s    = ~flush & ~stall_out & entry_valid_s & is_md_s;

    // Multdiv handshake FSM with registered start/timeout pulses
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            count_r      <= {CNT_W{1'b0}};
            md_start_r   <= 1'b0;
            md_timeout_r <= 1'b0;
        end else begin
            md_start_r   <= enter_md_s;
            md_timeout_r <= timeout_hit_s;
            if (enter_md_s) begin
                state_r <= ST_MD_WAIT;
                count_r <= {CNT_W{1'b0}};
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        state_r <= ST_IDLE;
                        count_r <= {CNT_W{1'b0}};
                    end
                    ST_MD_WAIT: begin
                        if (md_hold_s) begin
                            state_r <= ST_MD_WAIT;
                            count_r <= count_r + CNT_ONE;
                        end else begin
                            state_r <= ST_IDLE;
                            count_r <= {CNT_W{1'b0}};
                        end
                    end
                    default: begin
                        state_r <= ST_IDLE;
                        count_r <= {CNT_W{1'b0}};
                    end
                endcase
            end
        end
    end

    // Pipeline registers: flush bubbles stage 0 but lets older stages drain even under stall
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ctrl_r  <= '0;
            valid_r <= {STAGES{1'b0}};
        end else if (flush) begin
            ctrl_r[0]  <= 17'h00000;
            valid_r[0] <= 1'b0;
            for (int k = 1; k < STAGES; k++) begin
                ctrl_r[k]  <= ctrl_r[k-1];
                valid_r[k] <= valid_r[k-1];
            end
        end else if (!stall_out) begin
            ctrl_r[0]  <= entry_ctrl_s;
            valid_r[0] <= entry_valid_s;
            for (int k = 1; k < STAGES; k++) begin
                ctrl_r[k]  <= ctrl_r[k-1];
                valid_r[k] <= valid_r[k-1];
            end
        end else begin
            ctrl_r  <= ctrl_r;
            valid_r <= valid_r;
        end
    end

    assign ctrl_out   = ctrl_r;
    assign valid_out  = valid_r;
    assign md_start   = md_start_r;
    assign md_timeout = md_timeout_r;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed self-checking bench for pipe_ctrl_unit (STAGES=3, MD_TIMEOUT=64); honours PIPE_CTRL_ILLEGAL_EN.
module tb_pipe_ctrl_unit;

    localparam int STG = 3;
    localparam int MDT = 64;

    logic                 clock;
    logic                 reset;
    logic                 in_valid;
    logic [4:0]           op;
    logic [4:0]           aluop;
    logic                 stall_ext;
    logic                 flush;
    logic                 md_ready;
    logic [16:0]          dec_ctrl;
    logic                 dec_addi;
    logic                 dec_sw;
    logic                 dec_lw;
    logic [17*STG-1:0]    ctrl_out;
    logic [STG-1:0]       valid_out;
    logic                 stall_out;
    logic                 md_start;
    logic                 md_timeout;
    logic                 illegal_op;

    int n_checks = 0;
    int n_fail   = 0;

    logic [4:0]  tbl_op   [12];
    logic [16:0] tbl_ctrl [12];

    pipe_ctrl_unit #(.STAGES(STG), .MD_TIMEOUT(MDT)) dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .op         (op),
        .aluop      (aluop),
        .stall_ext  (stall_ext),
        .flush      (flush),
        .md_ready   (md_ready),
        .dec_ctrl   (dec_ctrl),
        .dec_addi   (dec_addi),
        .dec_sw     (dec_sw),
        .dec_lw     (dec_lw),
        .ctrl_out   (ctrl_out),
        .valid_out  (valid_out),
        .stall_out  (stall_out),
        .md_start   (md_start),
        .md_timeout (md_timeout),
        .illegal_op (illegal_op)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [16:0] stage_ctrl(input int k);
        return ctrl_out[17*k +: 17];
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drain();
        in_valid = 1'b0;
        op       = 5'b00000;
        aluop    = 5'b00000;
        repeat (STG) tick();
    endtask

    initial begin
        int hi;
        int to_seen;

        tbl_op[0]  = 5'b00000; tbl_ctrl[0]  = 17'h00004;
        tbl_op[1]  = 5'b00101; tbl_ctrl[1]  = 17'h00016;
        tbl_op[2]  = 5'b01000; tbl_ctrl[2]  = 17'h00017;
        tbl_op[3]  = 5'b00111; tbl_ctrl[3]  = 17'h00039;
        tbl_op[4]  = 5'b00001; tbl_ctrl[4]  = 17'h00200;
        tbl_op[5]  = 5'b00010; tbl_ctrl[5]  = 17'h00048;
        tbl_op[6]  = 5'b00011; tbl_ctrl[6]  = 17'h00384;
        tbl_op[7]  = 5'b00100; tbl_ctrl[7]  = 17'h00408;
        tbl_op[8]  = 5'b00110; tbl_ctrl[8]  = 17'h08008;
        tbl_op[9]  = 5'b10110; tbl_ctrl[9]  = 17'h11800;
        tbl_op[10] = 5'b10101; tbl_ctrl[10] = 17'h06004;
        tbl_op[11] = 5'b11111; tbl_ctrl[11] = 17'h00000;

        reset = 1'b1; in_valid = 1'b0; op = 5'b00000; aluop = 5'b00000;
        stall_ext = 1'b0; flush = 1'b0; md_ready = 1'b0;
        tick(); tick();
        check_val("rst_valid", valid_out, 3'b000);
        check_val("rst_ctrl", ctrl_out, 51'h0);
        check_val("rst_md_start", md_start, 1'b0);
        check_val("rst_md_timeout", md_timeout, 1'b0);
        check_val("rst_stall", stall_out, 1'b0);
        reset = 1'b0;

        // decode table
        for (int i = 0; i < 12; i++) begin
            op = tbl_op[i];
            #1;
            check_val($sformatf("dec_op%0d", i), dec_ctrl, tbl_ctrl[i]);
        end
        op = 5'b00111; #1;
        check_val("dec_sw_flag", dec_sw, 1'b1);
        check_val("dec_sw_addi", dec_addi, 1'b0);
        op = 5'b01000; #1;
        check_val("dec_lw_flag", dec_lw, 1'b1);

        // 1: addi flows down the pipe
        tick();
        in_valid = 1'b1; op = 5'b00101; #1;
        check_val("t1_dec", dec_ctrl, 17'h00016);
        check_val("t1_addi", dec_addi, 1'b1);
        check_val("t1_lw", dec_lw, 1'b0);
        tick();
        in_valid = 1'b0; op = 5'b00000;
        check_val("t1_s0_ctrl", stage_ctrl(0), 17'h00016);
        check_val("t1_v1", valid_out, 3'b001);
        tick();
        check_val("t1_s1_ctrl", stage_ctrl(1), 17'h00016);
        check_val("t1_v2", valid_out, 3'b010);
        tick();
        check_val("t1_s2_ctrl", stage_ctrl(2), 17'h00016);
        check_val("t1_v3", valid_out, 3'b100);

        // 2: lw then external stall for two cycles
        drain();
        check_val("t2_drained", valid_out, 3'b000);
        in_valid = 1'b1; op = 5'b01000;
        tick();
        op = 5'b00111; stall_ext = 1'b1; #1;
        check_val("t2_stall_a", stall_out, 1'b1);
        tick();
        check_val("t2_hold_v_a", valid_out, 3'b001);
        check_val("t2_hold_c_a", stage_ctrl(0), 17'h00017);
        check_val("t2_stall_b", stall_out, 1'b1);
        tick();
        check_val("t2_hold_v_b", valid_out, 3'b001);
        check_val("t2_hold_c_b", stage_ctrl(0), 17'h00017);
        stall_ext = 1'b0; #1;
        check_val("t2_unstall", stall_out, 1'b0);
        tick();
        in_valid = 1'b0; op = 5'b00000;
        check_val("t2_adv_v", valid_out, 3'b011);
        check_val("t2_adv_s0", stage_ctrl(0), 17'h00039);
        check_val("t2_adv_s1", stage_ctrl(1), 17'h00017);
        tick();
        check_val("t2_nodup_v", valid_out, 3'b110);
        check_val("t2_nodup_s1", stage_ctrl(1), 17'h00039);
        check_val("t2_nodup_s2", stage_ctrl(2), 17'h00017);

        // 3: mul released by md_ready
        drain();
        in_valid = 1'b1; op = 5'b00000; aluop = 5'b00110; #1;
        check_val("t3_pre_stall", stall_out, 1'b0);
        tick();
        op = 5'b00101; aluop = 5'b00000;
        check_val("t3_md_start", md_start, 1'b1);
        check_val("t3_s0", stage_ctrl(0), 17'h00004);
        #1;
        check_val("t3_stall0", stall_out, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val($sformatf("t3_start_low%0d", i), md_start, 1'b0);
            check_val($sformatf("t3_stall%0d", i + 1), stall_out, 1'b1);
            check_val($sformatf("t3_hold_v%0d", i), valid_out, 3'b001);
        end
        md_ready = 1'b1; #1;
        check_val("t3_ready_rel", stall_out, 1'b0);
        tick();
        md_ready = 1'b0; in_valid = 1'b0; op = 5'b00000; #1;
        check_val("t3_adv_v", valid_out, 3'b011);
        check_val("t3_adv_s0", stage_ctrl(0), 17'h00016);
        check_val("t3_adv_s1", stage_ctrl(1), 17'h00004);
        check_val("t3_no_to", md_timeout, 1'b0);
        check_val("t3_idle_stall", stall_out, 1'b0);
        md_ready = 1'b1;
        tick();
        md_ready = 1'b0; #1;
        check_val("t3_idle_ready_start", md_start, 1'b0);
        check_val("t3_idle_ready_stall", stall_out, 1'b0);

        // 4: mul with no md_ready times out; a div waits at decode
        drain();
        in_valid = 1'b1; op = 5'b00000; aluop = 5'b00110;
        tick();
        in_valid = 1'b0; aluop = 5'b00000;
        check_val("t4_md_start", md_start, 1'b1);
        #1;
        hi = 0; to_seen = 0;
        for (int i = 0; i < 200; i++) begin
            if (!stall_out) break;
            hi++;
            if (md_timeout) to_seen++;
            tick();
        end
        check_val("t4_stall_cycles", hi, MDT - 1);
        check_val("t4_early_to", to_seen, 0);
        in_valid = 1'b1; op = 5'b00000; aluop = 5'b00111;
        tick();
        in_valid = 1'b0; aluop = 5'b00000;
        check_val("t4_to_pulse", md_timeout, 1'b1);
        check_val("t4_b2b_start", md_start, 1'b1);
        check_val("t4_b2b_v", valid_out, 3'b011);
        #1;
        check_val("t4_b2b_stall", stall_out, 1'b1);

        // 5: flush in MD_WAIT with external stall
        stall_ext = 1'b1; flush = 1'b1; in_valid = 1'b1; op = 5'b00101; #1;
        check_val("t5_stall_ext_only", stall_out, 1'b1);
        tick();
        flush = 1'b0; stall_ext = 1'b0; in_valid = 1'b0; op = 5'b00000;
        check_val("t5_v", valid_out, 3'b110);
        check_val("t5_s0", stage_ctrl(0), 17'h00000);
        check_val("t5_s1", stage_ctrl(1), 17'h00004);
        check_val("t5_to", md_timeout, 1'b0);
        check_val("t5_start", md_start, 1'b0);
        #1;
        check_val("t5_idle", stall_out, 1'b0);
        tick();
        check_val("t5_to_after", md_timeout, 1'b0);

        // reset while waiting on multdiv
        drain();
        in_valid = 1'b1; op = 5'b00000; aluop = 5'b00110;
        tick();
        in_valid = 1'b0; aluop = 5'b00000;
        check_val("rw_start", md_start, 1'b1);
        #2 reset = 1'b1;
        #1;
        check_val("rw_start_clr", md_start, 1'b0);
        check_val("rw_valid_clr", valid_out, 3'b000);
        check_val("rw_stall_clr", stall_out, 1'b0);
        tick();
        reset = 1'b0;
        tick();
        check_val("rw_no_start", md_start, 1'b0);
        check_val("rw_no_to", md_timeout, 1'b0);
        check_val("rw_idle", stall_out, 1'b0);

        // 6: unknown opcode and out-of-range R-type aluop
        in_valid = 1'b1; op = 5'b11111; aluop = 5'b00000; #1;
`ifdef PIPE_CTRL_ILLEGAL_EN
        check_val("t6_illegal", illegal_op, 1'b1);
`else
        check_val("t6_illegal", illegal_op, 1'b0);
`endif
        tick();
`ifdef PIPE_CTRL_ILLEGAL_EN
        check_val("t6_s0_valid", valid_out[0], 1'b0);
`else
        check_val("t6_s0_valid", valid_out[0], 1'b1);
`endif
        check_val("t6_s0_ctrl", stage_ctrl(0), 17'h00000);
        op = 5'b00000; aluop = 5'b01001; #1;
        check_val("t6_alu9_legal", illegal_op, 1'b0);
        aluop = 5'b01010; #1;
`ifdef PIPE_CTRL_ILLEGAL_EN
        check_val("t6_alu10", illegal_op, 1'b1);
`else
        check_val("t6_alu10", illegal_op, 1'b0);
`endif
        tick();
        in_valid = 1'b0; aluop = 5'b00000;
`ifdef PIPE_CTRL_ILLEGAL_EN
        check_val("t6_alu10_v", valid_out[0], 1'b0);
`else
        check_val("t6_alu10_v", valid_out[0], 1'b1);
        check_val("t6_alu10_c", stage_ctrl(0), 17'h00004);
`endif
        check_val("t6_no_md", md_start, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
